// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo datapath definitions: tag/data/register widths, op codes and
// the CDB tag-match helper used by every operand slot.
package tomasulo_pkg;

  localparam int TAG_W    = 3;
  localparam int DATA_W   = 16;
  localparam int REGNUM_W = 3;
  localparam int OP_W     = 3;

  localparam logic [TAG_W-1:0] TAG_NONE = 3'd0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_MUL = 3'd7
  } op_e;

  // Tag 0 means "value present" and can never match a broadcast.
  function automatic logic tag_hit(input logic             valid,
                                   input logic [TAG_W-1:0] wait_tag,
                                   input logic [TAG_W-1:0] bus_tag);
    return valid && (wait_tag != TAG_NONE) && (wait_tag == bus_tag);
  endfunction

endpackage

// File: rtl/rs_operand.sv
// One reservation-station operand slot: holds a producer tag or a captured
// value, snoops the CDB, and bypasses a same-cycle broadcast at issue.
module rs_operand
  import tomasulo_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             busy_i,
  input  logic [TAG_W-1:0] iss_tag_i,
  input  logic [DW-1:0]    iss_val_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [DW-1:0]    cdb_data_i,
  output logic [DW-1:0]    val_o,
  output logic             rdy_o
);

  logic [TAG_W-1:0] tag_q, tag_d;
  logic [DW-1:0]    val_q, val_d;

  // Next tag/value: issue load (with bypass) takes priority over wakeup.
  always_comb begin
    tag_d = tag_q;
    val_d = val_q;
    if (load_i) begin
      if (tag_hit(cdb_valid_i, iss_tag_i, cdb_tag_i)) begin
        tag_d = TAG_NONE;
        val_d = cdb_data_i;
      end else begin
        tag_d = iss_tag_i;
        val_d = iss_val_i;
      end
    end else if (busy_i && tag_hit(cdb_valid_i, tag_q, cdb_tag_i)) begin
      tag_d = TAG_NONE;
      val_d = cdb_data_i;
    end else begin
      tag_d = tag_q;
      val_d = val_q;
    end
  end

  // Slot state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q <= TAG_NONE;
      val_q <= '0;
    end else begin
      tag_q <= tag_d;
      val_q <= val_d;
    end
  end

  assign val_o = val_q;
  assign rdy_o = (tag_q == TAG_NONE);

endmodule

// File: rtl/reservation_station.sv
// Tomasulo reservation station: lowest-free allocation, CDB wakeup via
// rs_operand slots, and oldest-ready selection toward one functional unit.
module reservation_station
  import tomasulo_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int TAG_BASE = 1,
  parameter int DW       = DATA_W
) (
  input  logic                CLK,
  input  logic                CLR,
  input  logic                iss_valid,
  output logic                iss_ready,
  input  logic [OP_W-1:0]     iss_op,
  input  logic [REGNUM_W-1:0] iss_dst,
  input  logic [TAG_W-1:0]    iss_tag0,
  input  logic [DW-1:0]       iss_val0,
  input  logic [TAG_W-1:0]    iss_tag1,
  input  logic [DW-1:0]       iss_val1,
  output logic [TAG_W-1:0]    alloc_tag,
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_tag,
  input  logic [DW-1:0]       cdb_data,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [OP_W-1:0]     ex_op,
  output logic [DW-1:0]       ex_a,
  output logic [DW-1:0]       ex_b,
  output logic [REGNUM_W-1:0] ex_dst,
  output logic [TAG_W-1:0]    ex_tag,
  output logic [DEPTH-1:0]    busy
);

  localparam int              AGE_W   = 3;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(DEPTH - 1);

  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [OP_W-1:0]     op_q  [DEPTH];
  logic [OP_W-1:0]     op_d  [DEPTH];
  logic [REGNUM_W-1:0] dst_q [DEPTH];
  logic [REGNUM_W-1:0] dst_d [DEPTH];
  logic [AGE_W-1:0]    age_q [DEPTH];
  logic [AGE_W-1:0]    age_d [DEPTH];
  logic [DW-1:0]       val0_s[DEPTH];
  logic [DW-1:0]       val1_s[DEPTH];
  logic [DEPTH-1:0]    rdy0_s, rdy1_s, ready_s, load_s;
  logic [DEPTH-1:0]    alloc_oh_s, sel_oh_s;
  logic [TAG_W-1:0]    alloc_tag_s;
  logic [AGE_W-1:0]    best_age_s;
  logic                full_s, issue_s, disp_s, take_s;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    rs_operand #(.DW(DW)) u_op0 (
      .clk_i(CLK), .rst_ni(CLR), .load_i(load_s[g]), .busy_i(busy_q[g]),
      .iss_tag_i(iss_tag0), .iss_val_i(iss_val0),
      .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
      .val_o(val0_s[g]), .rdy_o(rdy0_s[g])
    );
    rs_operand #(.DW(DW)) u_op1 (
      .clk_i(CLK), .rst_ni(CLR), .load_i(load_s[g]), .busy_i(busy_q[g]),
      .iss_tag_i(iss_tag1), .iss_val_i(iss_val1),
      .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
      .val_o(val1_s[g]), .rdy_o(rdy1_s[g])
    );
  end

  assign ready_s = busy_q & rdy0_s & rdy1_s;

  // Lowest-index free entry; scanning downward lets the lowest win.
  always_comb begin
    alloc_oh_s  = '0;
    alloc_tag_s = TAG_NONE;
    full_s      = 1'b1;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      alloc_oh_s  = busy_q[i] ? alloc_oh_s  : (DEPTH'(1) << i);
      alloc_tag_s = busy_q[i] ? alloc_tag_s : TAG_W'(TAG_BASE + i);
      full_s      = full_s & busy_q[i];
    end
  end

  assign iss_ready = ~full_s;
  assign alloc_tag = alloc_tag_s;
  assign issue_s   = iss_valid & ~full_s;
  assign load_s    = issue_s ? alloc_oh_s : '0;

  // Oldest-ready select; outputs stay zero when nothing is ready.
  always_comb begin
    sel_oh_s   = '0;
    best_age_s = '0;
    take_s     = 1'b0;
    ex_valid   = 1'b0;
    ex_op      = '0;
    ex_a       = '0;
    ex_b       = '0;
    ex_dst     = '0;
    ex_tag     = TAG_NONE;
    for (int i = 0; i < DEPTH; i++) begin
      take_s     = ready_s[i] & (~ex_valid | (age_q[i] > best_age_s));
      sel_oh_s   = take_s ? (DEPTH'(1) << i)      : sel_oh_s;
      best_age_s = take_s ? age_q[i]              : best_age_s;
      ex_op      = take_s ? op_q[i]               : ex_op;
      ex_a       = take_s ? val0_s[i]             : ex_a;
      ex_b       = take_s ? val1_s[i]             : ex_b;
      ex_dst     = take_s ? dst_q[i]              : ex_dst;
      ex_tag     = take_s ? TAG_W'(TAG_BASE + i)  : ex_tag;
      ex_valid   = ex_valid | take_s;
    end
  end

  assign disp_s = ex_valid & ex_ready;

  // Entry bookkeeping: fill on issue, age others on issue, free on dispatch.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < DEPTH; i++) begin
      op_d[i]   = op_q[i];
      dst_d[i]  = dst_q[i];
      age_d[i]  = age_q[i];
      busy_d[i] = load_s[i] | (busy_q[i] & ~(disp_s & sel_oh_s[i]));
      if (load_s[i]) begin
        op_d[i]  = iss_op;
        dst_d[i] = iss_dst;
        age_d[i] = '0;
      end else if (issue_s && busy_q[i]) begin
        age_d[i] = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + AGE_W'(1);
      end else begin
        age_d[i] = age_q[i];
      end
    end
  end

  // Entry state register.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      busy_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        dst_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= op_d[i];
        dst_q[i] <= dst_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station (DEPTH=3, TAG_BASE=1).
module tb_reservation_station;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        iss_valid, iss_ready;
  logic [2:0]  iss_op, iss_dst, iss_tag0, iss_tag1, alloc_tag;
  logic [15:0] iss_val0, iss_val1;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        ex_valid, ex_ready;
  logic [2:0]  ex_op, ex_dst, ex_tag;
  logic [15:0] ex_a, ex_b;
  logic [2:0]  busy;

  int checks = 0;
  int errors = 0;

  reservation_station dut (
    .CLK(CLK), .CLR(CLR),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_dst(iss_dst),
    .iss_tag0(iss_tag0), .iss_val0(iss_val0), .iss_tag1(iss_tag1), .iss_val1(iss_val1),
    .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
    .ex_dst(ex_dst), .ex_tag(ex_tag), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_iss(input logic v, input logic [2:0] op, input logic [2:0] dst,
                           input logic [2:0] t0, input logic [15:0] v0,
                           input logic [2:0] t1, input logic [15:0] v1);
    iss_valid = v;  iss_op = op;   iss_dst = dst;
    iss_tag0  = t0; iss_val0 = v0; iss_tag1 = t1; iss_val1 = v1;
  endtask

  task automatic drive_cdb(input logic v, input logic [2:0] t, input logic [15:0] d);
    cdb_valid = v; cdb_tag = t; cdb_data = d;
  endtask

  initial begin
    CLR = 1'b0;
    ex_ready = 1'b0;
    drive_iss(1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 3'd0, 16'h0);
    drive_cdb(1'b0, 3'd0, 16'h0);
    tick(); tick();
    check_eq("rst_iss_ready", 32'(iss_ready), 32'd1);
    check_eq("rst_alloc_tag", 32'(alloc_tag), 32'd1);
    check_eq("rst_ex_valid",  32'(ex_valid),  32'd0);
    check_eq("rst_busy",      32'(busy),      32'd0);
    CLR = 1'b1;
    tick();
    check_eq("idle_alloc_tag", 32'(alloc_tag), 32'd1);
    check_eq("idle_ex_a",      32'(ex_a),      32'd0);

    // Ready issue.
    drive_iss(1'b1, 3'd2, 3'd5, 3'd0, 16'h0010, 3'd0, 16'h0003);
    tick();
    drive_iss(1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 3'd0, 16'h0);
    check_eq("rdy_ex_valid", 32'(ex_valid), 32'd1);
    check_eq("rdy_ex_a",     32'(ex_a),     32'h0010);
    check_eq("rdy_ex_b",     32'(ex_b),     32'h0003);
    check_eq("rdy_ex_tag",   32'(ex_tag),   32'd1);
    check_eq("rdy_ex_dst",   32'(ex_dst),   32'd5);
    check_eq("rdy_ex_op",    32'(ex_op),    32'd2);
    check_eq("rdy_busy",     32'(busy),     32'b001);
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    check_eq("rdy_busy_after", 32'(busy),     32'b000);
    check_eq("rdy_ex_a_zero",  32'(ex_a),     32'd0);

    // Wakeup, with an unrelated broadcast first.
    drive_iss(1'b1, 3'd1, 3'd4, 3'd2, 16'h0000, 3'd0, 16'h0007);
    tick();
    drive_iss(1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 3'd0, 16'h0);
    check_eq("wk_wait_valid", 32'(ex_valid), 32'd0);
    drive_cdb(1'b1, 3'd5, 16'hBEEF);
    tick();
    check_eq("wk_nomatch_valid", 32'(ex_valid), 32'd0);
    drive_cdb(1'b1, 3'd2, 16'h00AA);
    check_eq("wk_bcast_cycle_valid", 32'(ex_valid), 32'd0);
    tick();
    drive_cdb(1'b0, 3'd0, 16'h0);
    check_eq("wk_ex_valid", 32'(ex_valid), 32'd1);
    check_eq("wk_ex_a",     32'(ex_a),     32'h00AA);
    check_eq("wk_ex_b",     32'(ex_b),     32'h0007);
    check_eq("wk_ex_tag",   32'(ex_tag),   32'd1);
    ex_ready = 1'b1; tick(); ex_ready = 1'b0;

    // Both operands wake on one broadcast; later broadcast must not overwrite.
    drive_iss(1'b1, 3'd3, 3'd6, 3'd3, 16'h0, 3'd3, 16'h0);
    tick();
    drive_iss(1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 3'd0, 16'h0);
    drive_cdb(1'b1, 3'd3, 16'h00BB);
    tick();
    drive_cdb(1'b1, 3'd3, 16'h0CCC);
    tick();
    drive_cdb(1'b0, 3'd0, 16'h0);
    check_eq("wk2_ex_a", 32'(ex_a), 32'h00BB);
    check_eq("wk2_ex_b", 32'(ex_b), 32'h00BB);
    ex_ready = 1'b1; tick(); ex_ready = 1'b0;

    // Issue-time bypass; cdb_tag 0 never matches a ready operand.
    drive_iss(1'b1, 3'd0, 3'd2, 3'd0, 16'h0005, 3'd3, 16'hDEAD);
    drive_cdb(1'b1, 3'd3, 16'h1234);
    tick();
    drive_iss(1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 3'd0, 16'h0);
    drive_cdb(1'b0, 3'd0, 16'h0);
    check_eq("byp_ex_valid", 32'(ex_valid), 32'd1);
    check_eq("byp_ex_b",     32'(ex_b),     32'h1234);
    check_eq("byp_ex_a",     32'(ex_a),     32'h0005);
    ex_ready = 1'b1; tick(); ex_ready = 1'b0;
    drive_iss(1'b1, 3'd0, 3'd2, 3'd0, 16'h0055, 3'd0, 16'h0001);
    drive_cdb(1'b1, 3'd0, 16'hFFFF);
    tick();
    drive_iss(1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 3'd0, 16'h0);
    drive_cdb(1'b0, 3'd0, 16'h0);
    check_eq("tag0_ex_a", 32'(ex_a), 32'h0055);
    ex_ready = 1'b1; tick(); ex_ready = 1'b0;

    // Fill, ignore issue while full, then drain oldest-first.
    for (int i = 1; i <= 3; i++) begin
      drive_iss(1'b1, 3'd1, 3'(i), 3'd0, 16'(i), 3'd0, 16'h0);
      check_eq("full_alloc_tag", 32'(alloc_tag), 32'(i));
      tick();
    end
    check_eq("full_iss_ready", 32'(iss_ready), 32'd0);
    check_eq("full_alloc_tag0", 32'(alloc_tag), 32'd0);
    check_eq("full_busy", 32'(busy), 32'b111);
    drive_iss(1'b1, 3'd1, 3'd6, 3'd0, 16'h0066, 3'd0, 16'h0);
    tick();
    drive_iss(1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 3'd0, 16'h0);
    check_eq("full_ignored_busy", 32'(busy), 32'b111);
    ex_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      check_eq("order_ex_dst", 32'(ex_dst), 32'(i));
      tick();
    end
    ex_ready = 1'b0;
    check_eq("order_empty_valid", 32'(ex_valid), 32'd0);
    check_eq("order_empty_busy",  32'(busy),     32'd0);

    // Concurrent dispatch while full: freed slot allocatable next cycle.
    for (int i = 1; i <= 3; i++) begin
      drive_iss(1'b1, 3'd1, 3'(i), 3'd0, 16'(i), 3'd0, 16'h0);
      tick();
    end
    drive_iss(1'b1, 3'd4, 3'd7, 3'd0, 16'h0077, 3'd0, 16'h0);
    ex_ready = 1'b1;
    check_eq("conc_iss_ready_t", 32'(iss_ready), 32'd0);
    check_eq("conc_ex_dst_t",    32'(ex_dst),    32'd1);
    tick();
    ex_ready = 1'b0;
    check_eq("conc_busy_t1",      32'(busy),      32'b110);
    check_eq("conc_alloc_tag_t1", 32'(alloc_tag), 32'd1);
    tick();
    drive_iss(1'b0, 3'd0, 3'd0, 3'd0, 16'h0, 3'd0, 16'h0);
    check_eq("conc_busy_full", 32'(busy), 32'b111);
    ex_ready = 1'b1;
    check_eq("conc_ord_dst2", 32'(ex_dst), 32'd2);
    tick();
    check_eq("conc_ord_dst3", 32'(ex_dst), 32'd3);
    tick();
    check_eq("conc_ord_dst7", 32'(ex_dst), 32'd7);
    check_eq("conc_ord_tag",  32'(ex_tag), 32'd1);
    check_eq("conc_ord_a",    32'(ex_a),   32'h0077);
    ex_ready = 1'b0;

    // Asynchronous reset mid-operation discards the remaining entry.
    #2 CLR = 1'b0;
    #1;
    check_eq("arst_busy",     32'(busy),     32'd0);
    check_eq("arst_ex_valid", 32'(ex_valid), 32'd0);
    tick();
    CLR = 1'b1;
    tick();
    check_eq("arst_iss_ready", 32'(iss_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
